// File: rtl/fpga_temp_monitor_pkg.sv
// Shared types and constants for the die-temperature monitor.
// Imported by the sequencer top and the overtemp flag sub-module.
package fpga_temp_mon_pkg;

    localparam int TEMP_W_DFLT = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_UPDATE
    } state_e;

    localparam logic [TEMP_W_DFLT-1:0] TEMP_MIN_RST = '1;
    localparam logic [TEMP_W_DFLT-1:0] TEMP_MAX_RST = '0;

endpackage

// File: rtl/fpga_temp_monitor_hyst.sv
// Hysteretic over-temperature flag, re-evaluated only on the update strobe.
// A set condition takes priority, so lo_thresh > hi_thresh still sets.
module fpga_temp_hyst
    import fpga_temp_mon_pkg::*;
#(
    parameter int TEMP_W = TEMP_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd,
    input  logic [TEMP_W-1:0] avg,
    input  logic [TEMP_W-1:0] hi_thresh,
    input  logic [TEMP_W-1:0] lo_thresh,
    output logic              flag
);

    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = flag_q;
        if (upd) begin
            if (avg >= hi_thresh) begin
                flag_d = 1'b1;
            end else if (avg < lo_thresh) begin
                flag_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/fpga_temp_monitor.sv
// Die-temperature sequencer: interval sampling, box-car average,
// min/max tracking with a 4-phase clear handshake, overtemp flag.
module fpga_temp_monitor
    import fpga_temp_mon_pkg::*;
#(
    parameter int TEMP_W     = TEMP_W_DFLT,
    parameter int SAMPLE_DIV = 1000,
    parameter int LOG2_NAVG  = 4
) (
    input  logic              lclk,
    input  logic              lclk_rst_n,
    input  logic              enable,
    input  logic [TEMP_W-1:0] device_temp_in,
    input  logic [TEMP_W-1:0] hi_thresh,
    input  logic [TEMP_W-1:0] lo_thresh,
    input  logic              clr_req,
    output logic              clr_ack,
    output logic [TEMP_W-1:0] temp_avg,
    output logic              avg_valid,
    output logic [TEMP_W-1:0] temp_min,
    output logic [TEMP_W-1:0] temp_max,
    output logic              overtemp,
    output logic [15:0]       avg_count
);

    localparam int ACC_W = TEMP_W + LOG2_NAVG;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = LOG2_NAVG + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << LOG2_NAVG) - 1);
    localparam logic [TEMP_W-1:0] MIN_RST  = {TEMP_W{TEMP_MIN_RST[0]}};
    localparam logic [TEMP_W-1:0] MAX_RST  = TEMP_W'(TEMP_MAX_RST);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [TEMP_W-1:0] avg_q, avg_d;
    logic              valid_q, valid_d;
    logic [TEMP_W-1:0] min_q, min_d;
    logic [TEMP_W-1:0] max_q, max_d;
    logic              ack_q, ack_d;
    logic [15:0]       count_q, count_d;

    logic [TEMP_W-1:0] avg_new;
    logic              upd;
    logic              clr;

    always_comb begin
        avg_new = TEMP_W'(acc_q >> LOG2_NAVG);
        upd     = (state_q == ST_UPDATE);
        clr     = clr_req && !ack_q;

        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        avg_d   = avg_q;
        valid_d = upd;
        count_d = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                    div_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (div_q == DIV_LAST) begin
                    state_d = ST_SAMPLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = acc_q + ACC_W'(device_temp_in);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == CNT_LAST) ? ST_UPDATE : ST_WAIT;
                end
            end
            ST_UPDATE: begin
                avg_d   = avg_new;
                count_d = count_q + 16'd1;
                acc_d   = '0;
                cnt_d   = '0;
                div_d   = '0;
                state_d = enable ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear lands before a coincident update so the new average reloads both.
        ack_d = ack_q;
        min_d = min_q;
        max_d = max_q;
        if (clr) begin
            ack_d = 1'b1;
            min_d = MIN_RST;
            max_d = MAX_RST;
        end else if (!clr_req) begin
            ack_d = 1'b0;
        end
        if (upd) begin
            if (avg_new < min_d) begin
                min_d = avg_new;
            end
            if (avg_new > max_d) begin
                max_d = avg_new;
            end
        end
    end

    always_ff @(posedge lclk) begin
        if (!lclk_rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            min_q   <= MIN_RST;
            max_q   <= MAX_RST;
            ack_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            min_q   <= min_d;
            max_q   <= max_d;
            ack_q   <= ack_d;
            count_q <= count_d;
        end
    end

    fpga_temp_hyst #(
        .TEMP_W(TEMP_W)
    ) u_hyst (
        .clk       (lclk),
        .rst_n     (lclk_rst_n),
        .upd       (upd),
        .avg       (avg_new),
        .hi_thresh (hi_thresh),
        .lo_thresh (lo_thresh),
        .flag      (overtemp)
    );

    assign clr_ack   = ack_q;
    assign temp_avg  = avg_q;
    assign avg_valid = valid_q;
    assign temp_min  = min_q;
    assign temp_max  = max_q;
    assign avg_count = count_q;

endmodule

// File: doc/fpga_temp_monitor.md
Name: fpga_temp_monitor

Overview:
Sequencer and statistics engine for the FPGA die temperature, all in the lclk domain. It consumes the 12-bit temperature after it has been synchronized into lclk. It samples the value at a programmable interval, box-car averages 2^LOG2_NAVG samples, and tracks min/max of the averages. It drives an over-temperature flag with hysteresis and provides a 4-phase handshake for clearing min/max from the slow-control register block.

Parameters:
TEMP_W, 12, temperature word width (device_temp format, unsigned)
SAMPLE_DIV, 1000, lclk cycles spent in WAIT between samples (>=1)
LOG2_NAVG, 4, log2 of samples per average (0..8)

Ports:
lclk  in  1  logic clock; sole clock of the block
lclk_rst_n  in  1  synchronous, active-low reset (lclk domain)
enable  in  1  run/stop for the sampling sequencer (level)
device_temp_in  in  TEMP_W  temperature, already synchronized to lclk
hi_thresh  in  TEMP_W  overtemp set threshold (static config)
lo_thresh  in  TEMP_W  overtemp clear threshold (static config)
clr_req  in  1  min/max clear request, 4-phase level
clr_ack  out  1  clear acknowledge, 4-phase level
temp_avg  out  TEMP_W  most recent average
avg_valid  out  1  one-cycle pulse when temp_avg/min/max/overtemp update
temp_min  out  TEMP_W  minimum average since reset/clear
temp_max  out  TEMP_W  maximum average since reset/clear
overtemp  out  1  hysteretic over-temperature flag
avg_count  out  16  number of averages completed; wraps at 0xFFFF->0

Behaviour:
- Reset (lclk_rst_n=0 at an lclk edge): state=IDLE, accumulator=0, sample counter=0, divider=0, temp_avg=0, avg_valid=0, temp_min=all-ones, temp_max=0, overtemp=0, clr_ack=0, avg_count=0. Reset mid-operation discards any partial accumulation.
- Accumulator width: TEMP_W+LOG2_NAVG. No overflow is possible. Average = acc >> LOG2_NAVG, truncating.
- FSM states: IDLE, WAIT, SAMPLE, UPDATE.
  - IDLE: enable=1 -> WAIT, with divider=0 and acc=0.
  - WAIT: divider increments each cycle. At divider==SAMPLE_DIV-1 -> SAMPLE, divider=0.
  - SAMPLE: acc += device_temp_in, sample counter increments. If this was sample 2^LOG2_NAVG-1 (0-based) -> UPDATE, else -> WAIT.
  - UPDATE: register temp_avg, min/max, overtemp and avg_count++. acc=0, sample counter=0. Next state is WAIT.
- Registered outputs and avg_valid become visible at the edge leaving UPDATE.
- enable=0 in WAIT or SAMPLE -> IDLE on the next edge; the partial acc is discarded. All outputs hold their last values.
- enable=0 while in UPDATE: the update completes, then the FSM goes to IDLE.
- Timing: period P = 2^LOG2_NAVG*(SAMPLE_DIV+1)+1 cycles. The first avg_valid is asserted P edges after the first edge that samples enable=1 in IDLE; subsequent pulses follow every P cycles.
- Min/max: on UPDATE, temp_min=min(temp_min,avg) and temp_max=max(temp_max,avg). The first average after reset/clear therefore loads both.
- Clear handshake:
  - When clr_req=1 and clr_ack=0: on the next edge temp_min=all-ones, temp_max=0, clr_ack=1.
  - clr_ack stays 1 until clr_req=0 is sampled, then returns to 0 on the next edge.
  - Clear is independent of the FSM state and of enable.
- Clear coinciding with UPDATE in the same cycle: the clear is applied first, then the new average. Result: temp_min=temp_max=avg, clr_ack=1.
- Overtemp (evaluated only in UPDATE): avg>=hi_thresh -> 1; else avg<lo_thresh -> 0; else hold. If lo_thresh>hi_thresh, the set condition wins.
- avg_count increments only in UPDATE and wraps 0xFFFF->0x0000.

Decomposition:
- Package fpga_temp_mon_pkg holds:
  - the state enum (IDLE/WAIT/SAMPLE/UPDATE);
  - TEMP_W default;
  - the reset constants TEMP_MIN_RST (all-ones) and TEMP_MAX_RST (0).
- One natural sub-module, fpga_temp_hyst: the overtemp comparator/flag. It takes avg, hi_thresh, lo_thresh and an update strobe, and holds the flag.
- Sequencer, accumulator, min/max and handshake stay in fpga_temp_monitor.

Test Plan:
- Base config for all cases: SAMPLE_DIV=3, LOG2_NAVG=2, so P=17.
- Constant input 0x800, enable raised -> avg_valid pulses at edges 17, 34, 51 after enable. temp_avg=temp_min=temp_max=0x800; avg_count=1, 2, 3.
- Samples 0x100, 0x101, 0x102, 0x103 -> temp_avg=0x101 (0x406>>2, truncated).
- Second window 0x200 x4 -> temp_min=0x101, temp_max=0x200.
- hi=0xA00, lo=0x900, averages 0x9FF, 0xA00, 0x950, 0x8FF -> overtemp 0, 1, 1, 0.
- After temp_max=0x200, assert clr_req -> next edge: clr_ack=1, min=0xFFF, max=0. Drop clr_req -> clr_ack=0 one edge later. Next average 0x180 loads min=max=0x180.
- Same clr_req timed so its clear edge coincides with UPDATE -> clr_ack=1 and min=max=new avg.
- Drop enable after 2 samples -> FSM in IDLE next edge, no avg_valid. Re-enable with input 0x400 -> first avg=0x400, arriving 17 edges later (earlier samples discarded).
- Pulse lclk_rst_n=0 for one edge mid-window -> all outputs at reset values on the next edge. With enable still high, the next avg_valid arrives 17 edges after the first post-reset edge.
